// File: rtl/pong_match_ctrl.sv
// Purpose : match sequencer for pong (idle / serve delay / live play / game over), scores and winner.
// Latency : start_evt 3 clk after raw start edge; state, scores and ball_reset update 1 clk after a miss.
// Backpr. : none; event inputs are pulses; events not relevant to the current state are ignored.
//
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   frame_tick                  1-cycle pulse per frame, counted only in SERVE
//   start_btn                   raw asynchronous start button
//   miss_left, miss_right       1-cycle miss pulses from the ball datapath
//   ball_enable, ball_reset     ball motion gate (level) and re-centre request (pulse)
//   serve_dir                   0 = serve toward left, 1 = toward right
//   score_l, score_r            player scores, saturating at WIN_SCORE
//   winner_valid, winner        winner flag (GAMEOVER only) and winning side (1 = right)
//   state_o                     IDLE=0 SERVE=1 PLAY=2 GAMEOVER=3
module pong_match_ctrl #(
    parameter int WIN_SCORE          = 9,
    parameter int SERVE_DELAY_FRAMES = 60,
    parameter int SCORE_W            = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               frame_tick,
    input  logic               start_btn,
    input  logic               miss_left,
    input  logic               miss_right,
    output logic               ball_enable,
    output logic               ball_reset,
    output logic               serve_dir,
    output logic [SCORE_W-1:0] score_l,
    output logic [SCORE_W-1:0] score_r,
    output logic               winner_valid,
    output logic               winner,
    output logic [1:0]         state_o
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SERVE    = 2'd1,
        PLAY     = 2'd2,
        GAMEOVER = 2'd3
    } state_t;

    localparam int                 CNT_W    = $clog2(SERVE_DELAY_FRAMES + 1);
    localparam logic [CNT_W-1:0]   CNT_LOAD = CNT_W'(SERVE_DELAY_FRAMES);
    localparam logic [SCORE_W-1:0] WIN      = SCORE_W'(WIN_SCORE);

    state_t             state, nxt_state;
    logic [CNT_W-1:0]   cnt, nxt_cnt;
    logic [SCORE_W-1:0] nxt_score_l, nxt_score_r;
    logic [SCORE_W-1:0] inc_l, inc_r;
    logic               nxt_serve_dir, nxt_winner, nxt_ball_reset;
    logic               sync1, sync2, sync3, start_evt;

    // Two flops to resolve metastability, a third to detect the rising edge;
    // the event itself is registered so a held button yields exactly one pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1     <= 1'b0;
            sync2     <= 1'b0;
            sync3     <= 1'b0;
            start_evt <= 1'b0;
        end else begin
            sync1     <= start_btn;
            sync2     <= sync1;
            sync3     <= sync2;
            start_evt <= sync2 & ~sync3;
        end
    end

    // Saturating increments; a score can never pass WIN_SCORE.
    assign inc_l = (score_l == WIN) ? score_l : score_l + SCORE_W'(1);
    assign inc_r = (score_r == WIN) ? score_r : score_r + SCORE_W'(1);

    always_comb begin
        nxt_state      = state;
        nxt_cnt        = cnt;
        nxt_score_l    = score_l;
        nxt_score_r    = score_r;
        nxt_serve_dir  = serve_dir;
        nxt_winner     = winner;
        nxt_ball_reset = 1'b0;
        unique case (state)
            IDLE: begin
                if (start_evt) begin
                    nxt_state      = SERVE;
                    nxt_score_l    = '0;
                    nxt_score_r    = '0;
                    nxt_ball_reset = 1'b1;
                    nxt_cnt        = CNT_LOAD;
                end
            end
            SERVE: begin
                // cnt holds the ticks still to wait; the last tick moves to PLAY.
                if (frame_tick) begin
                    nxt_cnt = cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        nxt_state = PLAY;
                    end
                end
            end
            PLAY: begin
                if (miss_left && miss_right) begin
                    // Simultaneous misses: replay the point, nobody scores.
                    nxt_state      = SERVE;
                    nxt_ball_reset = 1'b1;
                    nxt_cnt        = CNT_LOAD;
                end else if (miss_left || miss_right) begin
                    if (miss_left) begin
                        nxt_score_r   = inc_r;
                        nxt_serve_dir = 1'b0;
                    end else begin
                        nxt_score_l   = inc_l;
                        nxt_serve_dir = 1'b1;
                    end
                    if ((miss_left && inc_r == WIN) || (miss_right && inc_l == WIN)) begin
                        nxt_state  = GAMEOVER;
                        nxt_winner = miss_left;
                    end else begin
                        nxt_state      = SERVE;
                        nxt_ball_reset = 1'b1;
                        nxt_cnt        = CNT_LOAD;
                    end
                end
            end
            GAMEOVER: begin
                if (start_evt) begin
                    nxt_state      = SERVE;
                    nxt_score_l    = '0;
                    nxt_score_r    = '0;
                    nxt_serve_dir  = 1'b1;
                    nxt_ball_reset = 1'b1;
                    nxt_cnt        = CNT_LOAD;
                end
            end
            default: nxt_state = IDLE;
        endcase
    end

    // Level outputs are registered from the next state so they track state_o exactly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            score_l      <= '0;
            score_r      <= '0;
            serve_dir    <= 1'b1;
            winner       <= 1'b0;
            ball_reset   <= 1'b0;
            ball_enable  <= 1'b0;
            winner_valid <= 1'b0;
        end else begin
            state        <= nxt_state;
            cnt          <= nxt_cnt;
            score_l      <= nxt_score_l;
            score_r      <= nxt_score_r;
            serve_dir    <= nxt_serve_dir;
            winner       <= nxt_winner;
            ball_reset   <= nxt_ball_reset;
            ball_enable  <= (nxt_state == PLAY);
            winner_valid <= (nxt_state == GAMEOVER);
        end
    end

    assign state_o = state;

endmodule
